mem_traffic_checker: RTL and testbench
======================================

MEM_TRAFFIC_CHECKER -- requirements
Module: mem_traffic_checker

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of cache channels driven (1 = D$ only, 2 = I$ and D$).
REQ-002 SHALL have parameter NUM_WORDS, default 64, meaning words written and then verified per channel; power of 2, range 2..4096.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h00000000, meaning the byte address of word 0.
REQ-004 SHALL have parameter CH_OFFSET, default 32'h00100000, meaning the byte-address offset between channels (it forces eviction conflicts).
REQ-005 SHALL have parameter MAX_STALLS, default 50, meaning the number of consecutive stall cycles before timeout.
REQ-006 cpu_clk_g  in  1  sole clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 init_done  in  1  memory initialisation complete.
REQ-009 start  in  1  single-cycle pulse that begins a test run.
REQ-010 seed  in  32  data-pattern seed, latched on start.
REQ-011 stall  in  1  memory stall, shared by all channels.
REQ-012 addr  out  32*NUM_CH  per-channel byte address; channel 0 is D$, channel 1 is I$.
REQ-013 we  out  4*NUM_CH  per-channel byte write enables.
REQ-014 re  out  NUM_CH  per-channel read enables.
REQ-015 din  out  32*NUM_CH  per-channel write data.
REQ-016 dout  in  32*NUM_CH  per-channel read data.
REQ-017 busy, done, pass  out  1 each  run status flags.
REQ-018 fail_count  out  16  saturating count of mismatches.
REQ-019 first_fail_addr  out  32  address of the first mismatch.

Function
REQ-020 States SHALL be IDLE, WAIT_INIT, WRITE, READ, DRAIN, DONE and TIMEOUT.
REQ-021 IDLE->WAIT_INIT on start; WAIT_INIT->WRITE when init_done=1; start while busy SHALL be ignored.
REQ-022 A request SHALL be accepted at a rising edge with stall=0; while stall=1, addr/we/re/din SHALL hold their values.
REQ-023 WRITE SHALL issue word index i=0..NUM_WORDS-1, one per accepted cycle, on all channels simultaneously.
REQ-024 In WRITE, channel c SHALL drive addr=BASE_ADDR+c*CH_OFFSET+4*i, din=seed^addr^{c,i}, and we=4'b1111.
REQ-025 After index NUM_WORDS-1 is accepted in WRITE, the block SHALL move to READ with index 0 and we=0.
REQ-026 READ SHALL issue the same addresses with re=1; the read accepted at edge N SHALL be compared against dout at the next edge with stall=0.
REQ-027 READ SHALL be pipelined with one read outstanding and the next read issued at the same time, giving a throughput of 1 word/cycle when stall=0.
REQ-028 After the last read is accepted, DRAIN SHALL complete the final comparison and then go to DONE.
REQ-029 On a mismatch, fail_count SHALL increment by the number of mismatching channels that cycle, saturating at 16'hFFFF.
REQ-030 first_fail_addr SHALL be written only on the first mismatch of a run; if channels mismatch simultaneously, the lowest channel wins.
REQ-031 A stall counter SHALL reset on any stall=0 cycle; reaching MAX_STALLS SHALL force TIMEOUT from WRITE, READ or DRAIN.
REQ-032 In DONE and TIMEOUT: done=1, busy=0, and re/we=0; pass SHALL equal (fail_count==0) in DONE and be 0 in TIMEOUT.
REQ-033 start in DONE or TIMEOUT SHALL clear the counters and flags and re-enter WAIT_INIT.
REQ-034 busy SHALL be 1 in WAIT_INIT, WRITE, READ and DRAIN.
REQ-035 The word index SHALL be log2(NUM_WORDS) bits wide; the terminal-index compare SHALL occur before wrap and no wrap SHALL be issued.

Reset
REQ-036 On rst: state=IDLE; addr, din, we, re, fail_count and first_fail_addr =0; busy=done=pass=0; stall counter=0.
REQ-037 rst SHALL abort an in-flight run at the next edge with no further request issued, regardless of stall.

Structure
REQ-038 State encoding, the pattern function and the channel-index constants SHALL live in shared package mem_test_pkg.
REQ-039 Per-channel compare/flag logic SHALL be one sub-module, mem_lane_checker, instantiated NUM_CH times.

Verification
REQ-040 NUM_CH=2, NUM_WORDS=4, seed=0, ideal memory, stall=0 -> 4 writes then 4 reads in consecutive cycles; done with pass=1 and fail_count=0 within 11 cycles of init_done.
REQ-041 stall held 3 cycles during write index 2 -> addr/din stable across those cycles; run still passes.
REQ-042 Memory model corrupts D$ word 1 (bit 0 flipped) -> fail_count=1, first_fail_addr=32'h00000004, pass=0.
REQ-043 stall held for 50 cycles in READ -> TIMEOUT, done=1, pass=0, re=0.
REQ-044 rst pulsed during READ, then start again -> IDLE with outputs zero; the rerun passes.
REQ-045 Memory150 behind it on DDR2, NUM_CH=2, default parameters -> pass=1 with eviction traffic exercised.

Source files
------------

// File: rtl/mem_test_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_test_pkg
// Brief    : Shared state encoding, channel indices and data-pattern function
//            for the memory traffic checker.
// Revision : 1.0 - initial release
// ============================================================================
package mem_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ      = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_DONE      = 3'd5,
    ST_TIMEOUT   = 3'd6
  } state_e;

  localparam int CH_DCACHE = 0;
  localparam int CH_ICACHE = 1;

  // Word data is seed ^ addr ^ {channel, word index}, with the channel number
  // placed immediately above the idx_w-bit index.
  function automatic logic [31:0] pattern(
    input logic [31:0] seed,
    input logic [31:0] addr,
    input int unsigned ch,
    input int unsigned idx,
    input int unsigned idx_w
  );
    logic [31:0] tag;
    tag = (32'(ch) << idx_w) | 32'(idx);
    return seed ^ addr ^ tag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_checker.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_checker
// Brief    : One cache channel: request address/data generation and read-back
//            comparison against the expected pattern.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_checker
  import mem_test_pkg::*;
#(
  parameter int          CH        = 0,
  parameter int          IDX_W     = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] CH_OFFSET = 32'h0010_0000
) (
  input  logic [31:0]      i_seed,
  input  logic [IDX_W-1:0] i_req_idx,
  input  logic [IDX_W-1:0] i_chk_idx,
  input  logic             i_chk_en,
  input  logic [31:0]      i_rdata,
  output logic [31:0]      o_req_addr,
  output logic [31:0]      o_req_din,
  output logic [31:0]      o_chk_addr,
  output logic             o_mismatch
);

  localparam logic [31:0] LANE_BASE = BASE_ADDR + 32'(CH) * CH_OFFSET;

  logic [31:0] exp_data;

  always_comb begin
    o_req_addr = LANE_BASE + (32'(i_req_idx) << 2);
    o_req_din  = pattern(i_seed, o_req_addr, CH, 32'(i_req_idx), IDX_W);
    o_chk_addr = LANE_BASE + (32'(i_chk_idx) << 2);
    exp_data   = pattern(i_seed, o_chk_addr, CH, 32'(i_chk_idx), IDX_W);
    o_mismatch = i_chk_en && (i_rdata != exp_data);
  end

endmodule
`default_nettype wire

// File: rtl/mem_traffic_checker.sv
`default_nettype none
// ============================================================================
// Module   : mem_traffic_checker
// Brief    : Writes a seeded pattern to every cache channel, reads it back
//            pipelined, and reports mismatches, pass/fail and stall timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module mem_traffic_checker
  import mem_test_pkg::*;
#(
  parameter int          NUM_CH     = 2,
  parameter int          NUM_WORDS  = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] CH_OFFSET  = 32'h0010_0000,
  parameter int          MAX_STALLS = 50
) (
  input  logic                   cpu_clk_g,
  input  logic                   rst,
  input  logic                   init_done,
  input  logic                   start,
  input  logic [31:0]            seed,
  input  logic                   stall,
  output logic [32*NUM_CH-1:0]   addr,
  output logic [4*NUM_CH-1:0]    we,
  output logic [NUM_CH-1:0]      re,
  output logic [32*NUM_CH-1:0]   din,
  input  logic [32*NUM_CH-1:0]   dout,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [15:0]            fail_count,
  output logic [31:0]            first_fail_addr
);

  localparam int                IDX_W       = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_WORDS - 1);
  localparam int                SCNT_W      = $clog2(MAX_STALLS + 1);
  localparam logic [SCNT_W-1:0] STALL_LIMIT = SCNT_W'(MAX_STALLS);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    pend_idx_q, pend_idx_d;
  logic                pend_vld_q, pend_vld_d;
  logic [31:0]         seed_q, seed_d;
  logic [SCNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [32*NUM_CH-1:0] addr_q, addr_d;
  logic [32*NUM_CH-1:0] din_q, din_d;
  logic [4*NUM_CH-1:0]  we_q, we_d;
  logic [NUM_CH-1:0]    re_q, re_d;
  logic [15:0]         fail_count_q, fail_count_d;
  logic [31:0]         first_fail_addr_q, first_fail_addr_d;

  logic                load_req, req_wr, req_rd, clr_req, clr_run, active;
  logic                chk_fire;
  logic [16:0]         n_mis, fail_sum;
  logic [31:0]         hit_addr;

  logic [31:0]         lane_req_addr [NUM_CH];
  logic [31:0]         lane_req_din  [NUM_CH];
  logic [31:0]         lane_chk_addr [NUM_CH];
  logic [NUM_CH-1:0]   lane_mis;

  // The outstanding read's data is only valid at an edge where memory is not stalled.
  assign chk_fire = pend_vld_q && !stall && ((state_q == ST_READ) || (state_q == ST_DRAIN));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    mem_lane_checker #(
      .CH        (c),
      .IDX_W     (IDX_W),
      .BASE_ADDR (BASE_ADDR),
      .CH_OFFSET (CH_OFFSET)
    ) u_lane (
      .i_seed     (seed_q),
      .i_req_idx  (idx_d),
      .i_chk_idx  (pend_idx_q),
      .i_chk_en   (chk_fire),
      .i_rdata    (dout[c*32 +: 32]),
      .o_req_addr (lane_req_addr[c]),
      .o_req_din  (lane_req_din[c]),
      .o_chk_addr (lane_chk_addr[c]),
      .o_mismatch (lane_mis[c])
    );
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    seed_d      = seed_q;
    pend_vld_d  = pend_vld_q;
    pend_idx_d  = pend_idx_q;
    stall_cnt_d = '0;
    load_req    = 1'b0;
    req_wr      = 1'b0;
    req_rd      = 1'b0;
    clr_req     = 1'b0;
    clr_run     = 1'b0;
    active      = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);

    case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start) begin
          state_d    = ST_WAIT_INIT;
          seed_d     = seed;
          clr_run    = 1'b1;
          pend_vld_d = 1'b0;
        end
      end
      ST_WAIT_INIT: begin
        if (init_done) begin
          state_d  = ST_WRITE;
          idx_d    = '0;
          load_req = 1'b1;
          req_wr   = 1'b1;
        end
      end
      ST_WRITE: begin
        if (!stall) begin
          load_req = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_READ;
            idx_d   = '0;
            req_rd  = 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            req_wr = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (!stall) begin
          pend_vld_d = 1'b1;
          pend_idx_d = idx_q;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DRAIN;
            clr_req = 1'b1;
          end else begin
            idx_d    = idx_q + 1'b1;
            load_req = 1'b1;
            req_rd   = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!stall) begin
          pend_vld_d = 1'b0;
          state_d    = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (active && stall) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
      if (stall_cnt_d >= STALL_LIMIT) begin
        state_d    = ST_TIMEOUT;
        clr_req    = 1'b1;
        pend_vld_d = 1'b0;
      end
    end
  end

  // Request registers only move on an accepted edge, so they hold under stall.
  always_comb begin
    addr_d = addr_q;
    din_d  = din_q;
    we_d   = we_q;
    re_d   = re_q;
    if (clr_req) begin
      addr_d = '0;
      din_d  = '0;
      we_d   = '0;
      re_d   = '0;
    end else if (load_req) begin
      for (int c = 0; c < NUM_CH; c++) begin
        addr_d[c*32 +: 32] = lane_req_addr[c];
        din_d[c*32 +: 32]  = req_wr ? lane_req_din[c] : 32'h0;
        we_d[c*4 +: 4]     = {4{req_wr}};
        re_d[c]            = req_rd;
      end
    end
  end

  always_comb begin
    fail_count_d      = fail_count_q;
    first_fail_addr_d = first_fail_addr_q;
    n_mis             = '0;
    hit_addr          = '0;
    // Walk downward so the lowest mismatching channel supplies hit_addr.
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (lane_mis[c]) begin
        n_mis    = n_mis + 17'd1;
        hit_addr = lane_chk_addr[c];
      end
    end
    fail_sum = {1'b0, fail_count_q} + n_mis;
    if (clr_run) begin
      fail_count_d      = '0;
      first_fail_addr_d = '0;
    end else if (n_mis != 17'd0) begin
      if (fail_count_q == 16'h0) begin
        first_fail_addr_d = hit_addr;
      end
      fail_count_d = fail_sum[16] ? 16'hFFFF : fail_sum[15:0];
    end
  end

  always_ff @(posedge cpu_clk_g) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      idx_q             <= '0;
      pend_idx_q        <= '0;
      pend_vld_q        <= 1'b0;
      seed_q            <= '0;
      stall_cnt_q       <= '0;
      addr_q            <= '0;
      din_q             <= '0;
      we_q              <= '0;
      re_q              <= '0;
      fail_count_q      <= '0;
      first_fail_addr_q <= '0;
    end else begin
      state_q           <= state_d;
      idx_q             <= idx_d;
      pend_idx_q        <= pend_idx_d;
      pend_vld_q        <= pend_vld_d;
      seed_q            <= seed_d;
      stall_cnt_q       <= stall_cnt_d;
      addr_q            <= addr_d;
      din_q             <= din_d;
      we_q              <= we_d;
      re_q              <= re_d;
      fail_count_q      <= fail_count_d;
      first_fail_addr_q <= first_fail_addr_d;
    end
  end

  assign addr            = addr_q;
  assign din             = din_q;
  assign we              = we_q;
  assign re              = re_q;
  assign fail_count      = fail_count_q;
  assign first_fail_addr = first_fail_addr_q;
  assign busy            = (state_q == ST_WAIT_INIT) || active;
  assign done            = (state_q == ST_DONE) || (state_q == ST_TIMEOUT);
  assign pass            = (state_q == ST_DONE) && (fail_count_q == 16'h0);

endmodule
`default_nettype wire

// File: tb/tb_mem_traffic_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_traffic_checker
// Brief    : Directed bench for mem_traffic_checker, 2 channels x 4 words,
//            backed by an ideal synchronous memory with optional corruption.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_traffic_checker;

  logic        clk = 1'b0;
  logic        rst, init_done, start, stall;
  logic [31:0] seed;
  logic [63:0] addr, din, dout_tb;
  logic [7:0]  we;
  logic [1:0]  re;
  logic        busy, done, pass;
  logic [15:0] fail_count;
  logic [31:0] first_fail_addr;

  logic [31:0] mem [2][16];
  int          corrupt_w [2];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mem_traffic_checker #(
    .NUM_CH    (2),
    .NUM_WORDS (4)
  ) dut (
    .cpu_clk_g       (clk),
    .rst             (rst),
    .init_done       (init_done),
    .start           (start),
    .seed            (seed),
    .stall           (stall),
    .addr            (addr),
    .we              (we),
    .re              (re),
    .din             (din),
    .dout            (dout_tb),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .fail_count      (fail_count),
    .first_fail_addr (first_fail_addr)
  );

  // Ideal memory: one-cycle read latency, read data held while stalled.
  always @(posedge clk) begin
    if (!stall) begin
      for (int c = 0; c < 2; c++) begin
        if (we[c*4 +: 4] == 4'hF)
          mem[c][addr[c*32+2 +: 4]] <= din[c*32 +: 32];
        if (re[c])
          dout_tb[c*32 +: 32] <= mem[c][addr[c*32+2 +: 4]] ^
                                 ((corrupt_w[c] == int'(addr[c*32+2 +: 4])) ? 32'h1 : 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 60; k++) begin
      if (done) break;
      tick();
    end
    chk(tag, {63'h0, done}, 64'h1);
  endtask

  task automatic wait_re(input string tag);
    for (int k = 0; k < 30; k++) begin
      if (re != 2'b00) break;
      tick();
    end
    chk(tag, {62'h0, re}, 64'h3);
  endtask

  initial begin
    rst = 1'b1; init_done = 1'b0; start = 1'b0; stall = 1'b0; seed = 32'h0;
    dout_tb = '0;
    corrupt_w[0] = -1; corrupt_w[1] = -1;
    tick(); tick();

    chk("rst_addr", addr, 64'h0);
    chk("rst_din", din, 64'h0);
    chk("rst_we_re", {54'h0, we, re}, 64'h0);
    chk("rst_flags", {61'h0, busy, done, pass}, 64'h0);
    chk("rst_fail_count", {48'h0, fail_count}, 64'h0);
    chk("rst_first_fail", {32'h0, first_fail_addr}, 64'h0);

    // Basic run, seed 0, no stalls
    rst = 1'b0;
    tick();
    pulse_start();
    chk("wait_init_busy", {62'h0, busy, done}, 64'h2);
    tick();
    chk("wait_init_hold_we", {56'h0, we}, 64'h0);
    init_done = 1'b1;
    tick();
    chk("wr0_addr", addr, {32'h0010_0000, 32'h0000_0000});
    chk("wr0_din", din, {32'h0010_0004, 32'h0000_0000});
    chk("wr0_we_re", {54'h0, we, re}, {54'h0, 8'hFF, 2'b00});
    tick();
    chk("wr1_din", din, {32'h0010_0001, 32'h0000_0005});
    tick();
    chk("wr2_din", din, {32'h0010_000E, 32'h0000_000A});
    tick();
    chk("wr3_addr_din", {addr[31:0], din[31:0]}, {32'h0000_000C, 32'h0000_000F});
    chk("wr3_din_ch1", {32'h0, din[63:32]}, {32'h0, 32'h0010_000B});
    tick();
    chk("rd0_we_re", {54'h0, we, re}, {54'h0, 8'h00, 2'b11});
    chk("rd0_addr", addr, {32'h0010_0000, 32'h0000_0000});
    tick(); tick(); tick(); tick();
    chk("drain_state", {60'h0, re, busy, done}, 64'h2);
    tick();
    chk("done_flags", {61'h0, busy, done, pass}, 64'h3);
    chk("done_fail_count", {48'h0, fail_count}, 64'h0);

    // Stall during write index 2; start while busy must be ignored
    seed = 32'h1234_5678;
    pulse_start();
    chk("restart_cleared", {47'h0, fail_count, done}, 64'h0);
    tick();
    start = 1'b1; seed = 32'hFFFF_FFFF;
    tick();
    start = 1'b0; seed = 32'h0;
    tick();
    chk("stall_wr2_addr", addr, {32'h0010_0008, 32'h0000_0008});
    chk("stall_wr2_din", din, {32'h1224_5676, 32'h1234_5672});
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold_addr", addr, {32'h0010_0008, 32'h0000_0008});
      chk("stall_hold_din", din, {32'h1224_5676, 32'h1234_5672});
    end
    stall = 1'b0;
    wait_done("stall_run_done");
    chk("stall_run_pass", {48'h0, fail_count}, 64'h0);
    chk("stall_run_passflag", {63'h0, pass}, 64'h1);

    // Corrupt D$ word 1
    seed = 32'h0;
    corrupt_w[0] = 1;
    pulse_start();
    wait_done("corrupt_done");
    chk("corrupt_fail_count", {48'h0, fail_count}, 64'h1);
    chk("corrupt_first_addr", {32'h0, first_fail_addr}, 64'h4);
    chk("corrupt_pass", {63'h0, pass}, 64'h0);

    // Simultaneous mismatch on both channels at word 2: lowest channel wins
    corrupt_w[0] = 2; corrupt_w[1] = 2;
    pulse_start();
    wait_done("dual_done");
    chk("dual_fail_count", {48'h0, fail_count}, 64'h2);
    chk("dual_first_addr", {32'h0, first_fail_addr}, 64'h8);
    corrupt_w[0] = -1; corrupt_w[1] = -1;

    // Stall for MAX_STALLS cycles in READ
    pulse_start();
    wait_re("timeout_reach_read");
    stall = 1'b1;
    for (int k = 0; k < 49; k++) tick();
    chk("timeout_not_yet", {62'h0, busy, done}, 64'h2);
    tick();
    chk("timeout_flags", {61'h0, busy, done, pass}, 64'h2);
    chk("timeout_we_re", {54'h0, we, re}, 64'h0);
    stall = 1'b0;
    tick();

    // Reset mid-READ, then rerun
    pulse_start();
    wait_re("rst_reach_read");
    tick();
    rst = 1'b1;
    tick();
    chk("abort_addr_din", addr | din, 64'h0);
    chk("abort_we_re", {54'h0, we, re}, 64'h0);
    chk("abort_flags", {61'h0, busy, done, pass}, 64'h0);
    rst = 1'b0;
    tick();
    chk("abort_idle", {63'h0, busy}, 64'h0);
    seed = 32'hCAFE_F00D;
    pulse_start();
    wait_done("rerun_done");
    chk("rerun_pass", {47'h0, fail_count, pass}, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
